// File: rtl/brcomp_seq.sv
// brcomp_seq: multi-cycle branch comparator.
// Compares two WIDTH-bit operands SLICE bits per cycle, starting at the most
// significant slice, and stops at the first slice that differs. Signed ops
// flip the sign bit of both operands at capture, so every slice compare can
// stay unsigned. Results are held in registers until the next operation ends.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o    request handshake (ready only while idle)
//   rs1_data_i, rs2_data_i operands A and B
//   br_op_i                RISC-V branch funct3
//   rsp_valid_o/ready_i    response handshake (valid only while done)
//   br_less_o, br_equal_o  A < B (signed/unsigned per op), A == B
//   br_taken_o             branch condition true
//   br_illegal_o           funct3 was 010 or 011
//   busy_o                 an operation is in flight or awaiting acceptance
module brcomp_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] rs1_data_i,
   input  logic [WIDTH-1:0] rs2_data_i,
   input  logic [2:0]       br_op_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             br_less_o,
   output logic             br_equal_o,
   output logic             br_taken_o,
   output logic             br_illegal_o,
   output logic             busy_o
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [IDXW-1:0]  idx, idx_nxt;
   logic [WIDTH-1:0] a_op, b_op;
   logic [2:0]       op;
   logic             less, equal, taken, illegal;
   logic             less_nxt, equal_nxt, taken_nxt, illegal_nxt;
   logic [SLICE-1:0] a_sl, b_sl;
   logic             slice_diff;
   logic             is_signed;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   function automatic logic [WIDTH-1:0] bias(input logic [WIDTH-1:0] v,
                                             input logic sgn);
      logic [WIDTH-1:0] r;
      r = v;
      r[WIDTH-1] = v[WIDTH-1] ^ sgn;
      return r;
   endfunction

   function automatic logic taken_of(input logic [2:0] f3, input logic lt,
                                     input logic eq);
      logic t;
      case (f3)
         3'b000:          t = eq;
         3'b001:          t = ~eq;
         3'b100, 3'b110:  t = lt;
         3'b101, 3'b111:  t = ~lt;
         default:         t = 1'b0;
      endcase
      return t;
   endfunction

   assign is_signed  = br_op_i[2] & ~br_op_i[1];
   assign a_sl       = a_op[int'(idx)*SLICE +: SLICE];
   assign b_sl       = b_op[int'(idx)*SLICE +: SLICE];
   assign slice_diff = (a_sl != b_sl);

   assign req_ready_o  = (state == IDLE);
   assign rsp_valid_o  = (state == DONE);
   assign busy_o       = (state != IDLE);
   assign br_less_o    = less;
   assign br_equal_o   = equal;
   assign br_taken_o   = taken;
   assign br_illegal_o = illegal;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         idx     <= '0;
         less    <= 1'b0;
         equal   <= 1'b0;
         taken   <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         less    <= less_nxt;
         equal   <= equal_nxt;
         taken   <= taken_nxt;
         illegal <= illegal_nxt;
      end
   end

   // Operand capture needs no reset: it is only read after an accept.
   always_ff @(posedge clk_i) begin
      if (state == IDLE && req_valid_i) begin
         a_op <= bias(rs1_data_i, is_signed);
         b_op <= bias(rs2_data_i, is_signed);
         op   <= br_op_i;
      end
   end

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      less_nxt    = less;
      equal_nxt   = equal;
      taken_nxt   = taken;
      illegal_nxt = illegal;
      case (state)
         IDLE: begin
            if (req_valid_i) begin
               state_nxt = BUSY;
               idx_nxt   = IDXW'(NSLICE - 1);
            end
         end
         BUSY: begin
            // The first differing slice from the top decides the order;
            // reaching slice 0 without a difference means equal.
            if (slice_diff || idx == '0) begin
               state_nxt   = DONE;
               less_nxt    = slice_diff & (a_sl < b_sl);
               equal_nxt   = ~slice_diff;
               taken_nxt   = taken_of(op, less_nxt, equal_nxt);
               illegal_nxt = (op[2:1] == 2'b01);
            end else begin
               idx_nxt = idx - IDXW'(1);
            end
         end
         DONE: begin
            if (rsp_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_brcomp_seq.sv
module tb_brcomp_seq;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 8;
   localparam int NSLICE = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] rs1, rs2;
   logic [2:0]       br_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             br_less, br_equal, br_taken, br_illegal, busy;

   brcomp_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .rs1_data_i(rs1), .rs2_data_i(rs2), .br_op_i(br_op),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .br_less_o(br_less), .br_equal_o(br_equal), .br_taken_o(br_taken),
      .br_illegal_o(br_illegal), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic less, equal, taken, illegal;
      int   edges;   // edges from accept (inclusive) to rsp_valid rising
      int   acc;     // cycle number of the accepting edge
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   ready_mode = 0;   // 0 random, 1 hold low, 2 hold high

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: direct signed/unsigned arithmetic; latency from the
   // position of the most significant differing bit.
   function automatic exp_t model(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [2:0] f3);
      exp_t e;
      logic [WIDTH-1:0] x;
      int h;
      if (f3 == 3'b100 || f3 == 3'b101) e.less = ($signed(a) < $signed(b));
      else                              e.less = (a < b);
      e.equal   = (a == b);
      e.illegal = (f3 == 3'b010 || f3 == 3'b011);
      case (f3)
         3'b000:  e.taken = e.equal;
         3'b001:  e.taken = !e.equal;
         3'b100, 3'b110: e.taken = e.less;
         3'b101, 3'b111: e.taken = !e.less;
         default: e.taken = 1'b0;
      endcase
      x = a ^ b;
      h = -1;
      for (int i = 0; i < WIDTH; i++) if (x[i]) h = i;
      if (h < 0) e.edges = NSLICE + 1;
      else       e.edges = NSLICE - (h / SLICE) + 1;
      e.acc = 0;
      return e;
   endfunction

   // Call at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] f3);
      exp_t e;
      int k;
      k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         chk("req_ready_wait", 32'(req_ready), 32'd1);
         return;
      end
      rs1 = a; rs2 = b; br_op = f3; req_valid = 1'b1;
      e = model(a, b, f3);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      rs1 = $urandom; rs2 = $urandom; br_op = 3'($urandom);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((sb.size() != 0 || rsp_valid) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Response acceptance, driven mid-cycle after each rising edge.
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            1:       rsp_ready = 1'b0;
            2:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboard when a response appears and checks that
   // it stays stable while held.
   initial begin
      exp_t e;
      logic in_done;
      logic [3:0] held;
      in_done = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            in_done = 1'b0;
         end else if (rsp_valid) begin
            if (!in_done) begin
               in_done = 1'b1;
               held = {br_less, br_equal, br_taken, br_illegal};
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("less",    32'(br_less),    32'(e.less));
                  chk("equal",   32'(br_equal),   32'(e.equal));
                  chk("taken",   32'(br_taken),   32'(e.taken));
                  chk("illegal", 32'(br_illegal), 32'(e.illegal));
                  chk("latency", 32'(cyc - e.acc + 1), 32'(e.edges));
               end
            end else begin
               chk("hold_flags", 32'({br_less, br_equal, br_taken, br_illegal}),
                   32'(held));
               chk("hold_req_ready", 32'(req_ready), 32'd0);
               chk("hold_busy", 32'(busy), 32'd1);
            end
         end else begin
            in_done = 1'b0;
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] a, b;
      int s;
      rst_ni = 1'b0; req_valid = 1'b0;
      rs1 = '0; rs2 = '0; br_op = '0;
      #3;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_flags", 32'({br_less, br_equal, br_taken, br_illegal}), 32'd0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);

      // Directed cases.
      issue(32'hDEADBEEF, 32'hDEADBEEF, 3'b000);
      issue(32'hFFFFFFFF, 32'h00000001, 3'b100);
      issue(32'hFFFFFFFF, 32'h00000001, 3'b110);
      issue(32'h12345678, 32'h12345679, 3'b101);
      issue(32'h12345678, 32'h12345679, 3'b001);
      issue(32'h00000001, 32'h00000002, 3'b011);
      drain();

      // Back-pressure: response held for several cycles, then released.
      ready_mode = 1;
      @(negedge clk);
      issue(32'h80000000, 32'h7FFFFFFF, 3'b101);
      s = 0;
      while (!rsp_valid && s < 50) begin
         @(negedge clk);
         s++;
      end
      chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
      repeat (3) @(negedge clk);
      ready_mode = 2;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("bp_release_req_ready", 32'(req_ready), 32'd1);
      chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
      ready_mode = 0;
      @(negedge clk);

      // Reset in the second BUSY cycle aborts without a response.
      issue(32'hCAFEF00D, 32'hCAFEF00D, 3'b000);
      @(posedge clk);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_flags", 32'({br_less, br_equal, br_taken, br_illegal}), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      issue(32'h0, 32'h0, 3'b000);
      drain();

      // Random traffic: equal operands, single-slice differences, free values.
      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         case ($urandom_range(0, 2))
            0: b = a;
            1: begin
               s = $urandom_range(0, NSLICE - 1);
               b = a ^ (WIDTH'($urandom_range(1, (1 << SLICE) - 1)) << (s * SLICE));
            end
            default: b = $urandom;
         endcase
         issue(a, b, 3'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
